// File: rtl/instr_packer.sv
// instr_packer: packs RISC-V fields into 32-bit words, buffers them in a
// small FIFO and streams them to instruction memory at incrementing addresses.
module instr_packer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       base_load,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd,
  input  logic [2:0]                 funct3,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [6:0]                 funct7,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [31:0]                wr_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr;
  logic              err_q;

  logic [31:0] word;
  logic        legal;
  logic        push;
  logic        store;
  logic        pop;

  assign word  = {funct7, rs2, rs1, funct3, rd, opcode};
  assign legal = (opcode[1:0] == 2'b11);

  assign in_ready = (cnt != FULL);
  assign wr_valid = (cnt != '0);

  assign push  = in_valid && in_ready;
  assign store = push && legal;
  assign pop   = wr_valid && wr_ready;

  assign wr_data = mem[rptr];
  assign wr_addr = addr;
  assign count   = cnt;
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      addr  <= '0;
      err_q <= 1'b0;
    end else begin
      if (store) begin
        mem[wptr] <= word;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case (1'b1)
        (store && !pop): cnt <= cnt + 1'b1;
        (pop && !store): cnt <= cnt - 1'b1;
        default:         cnt <= cnt;
      endcase
      // base_load overrides a same-cycle pop increment
      if (base_load) begin
        addr  <= {base_addr[ADDR_W-1:2], 2'b00};
        err_q <= 1'b0;
      end else begin
        if (pop) begin
          addr <= addr + ADDR_W'(4);
        end
        if (push && !legal) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: directed stimulus with a queue scoreboard and an
// independent write-port monitor.
module tb_instr_packer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              base_load = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        opcode = '0;
  logic [4:0]        rd = '0;
  logic [2:0]        funct3 = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [6:0]        funct7 = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [2:0]        count;
  logic              err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t sb[$];

  instr_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .base_load(base_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every completed write must match the queue head
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h",
                 wr_addr, wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_base(input logic [ADDR_W-1:0] a);
    base_addr = a;
    base_load = 1'b1;
    tick();
    base_load = 1'b0;
  endtask

  task automatic push(input logic [6:0] f7, input logic [4:0] r2,
                      input logic [4:0] r1, input logic [2:0] f3,
                      input logic [4:0] d, input logic [6:0] op,
                      input logic [ADDR_W-1:0] ea, input logic [31:0] ed,
                      input bit keep);
    bit rdy;
    int n;
    funct7 = f7; rs2 = r2; rs1 = r1;
    funct3 = f3; rd = d; opcode = op;
    if (keep) sb.push_back('{addr: ea, data: ed});
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    in_valid = 1'b0;
    if (!rdy) chk("push_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (count != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2
    wr_ready = 1'b1;
    push(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33, 10'h000, 32'h002081B3, 1);
    @(negedge clk);
    chk("t1_wr_valid", 32'(wr_valid), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("t1_next_addr", 32'(wr_addr), 32'h004);
    chk("t1_next_count", 32'(count), 32'd0);
    tick();

    // sub x5,x6,x7 after base 0x103
    do_base(10'h103);
    chk("t2_base", 32'(wr_addr), 32'h100);
    push(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, 7'h33, 10'h100, 32'h407302B3, 1);
    drain();

    // fill with back-pressure, stall the fifth
    wr_ready = 1'b0;
    do_base(10'h000);
    push(7'h00, 5'd1, 5'd0, 3'd0, 5'd1, 7'h13, 10'h000, 32'h00100093, 1);
    push(7'h00, 5'd2, 5'd0, 3'd0, 5'd2, 7'h13, 10'h004, 32'h00200113, 1);
    push(7'h7F, 5'h1F, 5'h1F, 3'd7, 5'h1F, 7'h7F, 10'h008, 32'hFFFFFFFF, 1);
    push(7'h00, 5'd0, 5'd0, 3'd0, 5'd0, 7'h37, 10'h00C, 32'h00000037, 1);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_hold_valid", 32'(wr_valid), 32'd1);
    funct7 = 7'h01; rs2 = 5'd3; rs1 = 5'd2;
    funct3 = 3'd4; rd = 5'd4; opcode = 7'h33;
    in_valid = 1'b1;
    tick();
    tick();
    chk("t3_stall_count", 32'(count), 32'd4);
    chk("t3_hold_addr", 32'(wr_addr), 32'h000);
    chk("t3_hold_data", wr_data, 32'h00100093);
    wr_ready = 1'b1;
    push(7'h01, 5'd3, 5'd2, 3'd4, 5'd4, 7'h33, 10'h010, 32'h02314233, 1);
    drain();

    // illegal opcode dropped, err sticky until base_load
    push(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h30, 10'h000, 32'h0, 0);
    @(negedge clk);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_wr_valid", 32'(wr_valid), 32'd0);
    tick();
    chk("t4_err_sticky", 32'(err), 32'd1);
    do_base(10'h000);
    chk("t4_err_clr", 32'(err), 32'd0);

    // address wrap
    do_base(10'h3FC);
    push(7'h00, 5'd1, 5'd0, 3'd0, 5'd1, 7'h13, 10'h3FC, 32'h00100093, 1);
    push(7'h00, 5'd2, 5'd0, 3'd0, 5'd2, 7'h13, 10'h000, 32'h00200113, 1);
    drain();
    tick();
    chk("t5_wrap_addr", 32'(wr_addr), 32'h004);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // async reset mid-stream
    wr_ready = 1'b0;
    push(7'h00, 5'd1, 5'd0, 3'd0, 5'd1, 7'h13, 10'h004, 32'h00100093, 1);
    push(7'h00, 5'd2, 5'd0, 3'd0, 5'd2, 7'h13, 10'h008, 32'h00200113, 1);
    push(7'h00, 5'd0, 5'd0, 3'd0, 5'd0, 7'h37, 10'h00C, 32'h00000037, 1);
    chk("t6_count3", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_valid", 32'(wr_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_addr", 32'(wr_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_packer.md
# instr_packer

The instr_packer is the write-side counterpart of the instruction field decoder. It accepts RISC-V instruction fields (opcode, rd, funct3, rs1, rs2, funct7) over a valid/ready handshake and packs them into 32-bit instruction words. It buffers the words in a DEPTH-entry FIFO and streams them into instruction memory through a write port with an auto-incrementing byte address. It is used by the test loader and boot path to populate instruction memory ahead of fetch.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 10, byte-address width of the instruction-memory write port
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- base_load  input  1  load the address counter from base_addr and clear err
- base_addr  input  ADDR_W  new base byte address; bits [1:0] are ignored (forced to 0)
- in_valid  input  1  field set is presented
- in_ready  output  1  packer can accept a field set
- opcode  input  7  instruction[6:0]
- rd  input  5  instruction[11:7]
- funct3  input  3  instruction[14:12]
- rs1  input  5  instruction[19:15]
- rs2  input  5  instruction[24:20]
- funct7  input  7  instruction[31:25]
- wr_valid  output  1  head word is available for write
- wr_ready  input  1  memory accepts the write this cycle
- wr_addr  output  ADDR_W  byte address for the head word
- wr_data  output  32  head word
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- err  output  1  sticky flag; a field set with an illegal opcode was dropped

## Operation
- Packing: the word is {funct7, rs2, rs1, funct3, rd, opcode}, which is the exact inverse of the decoder field map.
- Push: a push occurs when in_valid && in_ready.
  - If opcode[1:0] == 2'b11, the packed word is written at the tail.
  - Otherwise the set is consumed but not stored, and err sets. err stays set until base_load or reset.
- in_ready = (count != DEPTH). This is a registered-occupancy compare with no combinational path from wr_ready.
- Pop: a pop occurs when wr_valid && wr_ready. The head advances and the address counter adds 4, modulo 2^ADDR_W (wraps silently).
- wr_valid = (count != 0). wr_data is the head entry and wr_addr is the address counter, both driven from registers.
- Push and pop in the same cycle (non-full, non-empty): count is unchanged and both pointers advance.
- Push when full is impossible because in_ready is 0. Pop when empty is impossible because wr_valid is 0. There is no bypass, so an empty FIFO yields its first wr_valid one cycle after the push.
- base_load:
  - Address counter ← {base_addr[ADDR_W-1:2], 2'b00} and err ← 0 on the next edge.
  - base_load wins over a same-cycle pop increment; that pop still used the old wr_addr.
  - FIFO contents and pointers are untouched.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is maintained as a separate counter.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream) forces:
  - count=0, pointers=0, address counter=0, err=0
  - wr_valid=0, in_ready=1, wr_addr=0
- wr_data is don't-care while wr_valid=0.
- Reset mid-stream discards all buffered words. No write handshake completes in the reset cycle.
- Latency is 1 cycle from push to wr_valid when empty. Throughput is 1 word/cycle under continuous in_valid and wr_ready.
- wr_valid, wr_addr and wr_data hold stable while wr_valid && !wr_ready.
- An illegal-opcode push sets err on the same edge as the would-be push. count does not change for it.

## Test plan
- Reset, then push add x3,x1,x2 (opcode 0x33, rd 3, f3 0, rs1 1, rs2 2, f7 0) with wr_ready=1 → next cycle wr_valid=1, wr_data=0x002081B3, wr_addr=0x000; the cycle after that wr_addr=0x004 and count=0.
- base_load with base_addr=0x103, then push sub x5,x6,x7 (f7 0x20) → wr_addr=0x100, wr_data=0x407302B3.
- Hold wr_ready=0 and push 5 words with DEPTH=4 → in_ready=0 after the 4th, count=4, and the 5th is stalled. Release wr_ready → words drain in order at addresses 0,4,8,C, then the 5th at 0x10.
- Push opcode=0x30 → err=1, count stays 0, no write. Then base_load → err=0.
- base_load with base_addr=0x3FC (ADDR_W=10), then 2 pops → wr_addr 0x3FC then 0x000. Also assert rst_n low while count=3 → count=0 and wr_valid=0 immediately (asynchronously).
